// File: rtl/alu_matrix_stream.sv
// -----------------------------------------------------------------------------
// alu_matrix_stream
//   Streaming NxN matrix ALU. Two operand matrices (A, then B) arrive one
//   element per accepted transfer in row-major order. The selected operation
//   is then computed into an internal result matrix C. C is then streamed out
//   row-major over a valid/ready port.
//
//   Ops (sel): 0 ADD  C = A + B
//              1 SUB  C = A - B
//              2 HAD  C[i][j] = A[i][j] * B[i][j]
//              3 MUL  C = A * B (matrix product, one MAC per cycle)
//              4 TRN  C = A^T (no B load phase)
//              5..7   illegal: err pulse, stays idle
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-low reset
//   start, sel   begin an operation / op code (sampled in IDLE only)
//   eleInValid   operand element valid
//   eleIn        operand element
//   eleInReady   operand element accepted this cycle when valid
//   eleOutValid  result element valid
//   eleOut       result element
//   eleOutReady  sink accepts the result element
//   busy         high outside IDLE
//   done         one-cycle pulse after the last result is accepted
//   ovf          sticky overflow of the current op, cleared by an accepted start
//   err          one-cycle pulse for an illegal sel at start
// -----------------------------------------------------------------------------
module alu_matrix_stream #(
    parameter int W    = 32,
    parameter int N    = 4,
    parameter int SELW = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [SELW-1:0] sel,
    input  logic            eleInValid,
    input  logic [W-1:0]    eleIn,
    output logic            eleInReady,
    output logic            eleOutValid,
    output logic [W-1:0]    eleOut,
    input  logic            eleOutReady,
    output logic            busy,
    output logic            done,
    output logic            ovf,
    output logic            err
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    // Full product plus headroom for N accumulated products.
    localparam int AW = 2 * W + CW;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [SELW-1:0] OP_ADD = SELW'(0);
    localparam logic [SELW-1:0] OP_SUB = SELW'(1);
    localparam logic [SELW-1:0] OP_HAD = SELW'(2);
    localparam logic [SELW-1:0] OP_MUL = SELW'(3);
    localparam logic [SELW-1:0] OP_TRN = SELW'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_COMPUTE,
        S_DRAIN
    } state_t;

    state_t          state, state_nxt;
    logic [SELW-1:0] op;

    // Shared row/column position used by load, compute and drain; kk is the
    // inner (dot-product) index for MUL.
    logic [CW-1:0]   row, col, kk;
    logic [CW-1:0]   row_inc, col_inc;
    logic            last_pos;

    logic [W-1:0]    mat_a [N][N];
    logic [W-1:0]    mat_b [N][N];
    logic [W-1:0]    mat_c [N][N];

    logic            take_in, take_out, sel_legal;
    logic [W-1:0]    a_el, b_el;
    logic [W:0]      sum;
    logic [2*W-1:0]  had_prod, mac_prod;
    logic [AW-1:0]   acc, acc_nxt;
    logic [W-1:0]    c_wdata;
    logic            c_we, step_ovf, comp_step;

    assign eleInReady = (state == S_LOAD_A) || (state == S_LOAD_B);
    assign busy       = (state != S_IDLE);
    assign take_in    = eleInValid && eleInReady;
    assign take_out   = eleOutValid && eleOutReady;
    assign sel_legal  = (sel <= OP_TRN);
    assign last_pos   = (row == LAST) && (col == LAST);

    // Row-major successor of (row, col); wraps to (0, 0) after the last element
    // so every phase starts from the origin.
    always_comb begin
        col_inc = col + 1'b1;
        row_inc = row;
        if (col == LAST) begin
            col_inc = '0;
            row_inc = (row == LAST) ? '0 : row + 1'b1;
        end
    end

    // Per-step result for the element at (row, col).
    always_comb begin
        a_el      = mat_a[row][col];
        b_el      = mat_b[row][col];
        sum       = {1'b0, a_el} + {1'b0, b_el};
        had_prod  = {{W{1'b0}}, a_el} * {{W{1'b0}}, b_el};
        mac_prod  = {{W{1'b0}}, mat_a[row][kk]} * {{W{1'b0}}, mat_b[kk][col]};
        // First MAC of a dot product starts a fresh sum.
        acc_nxt   = ((kk == '0) ? '0 : acc) + {{CW{1'b0}}, mac_prod};
        c_wdata   = '0;
        step_ovf  = 1'b0;
        comp_step = 1'b1;
        case (op)
            OP_ADD: begin
                c_wdata  = sum[W-1:0];
                step_ovf = sum[W];
            end
            OP_SUB: begin
                c_wdata  = a_el - b_el;
                step_ovf = (a_el < b_el);
            end
            OP_HAD: begin
                c_wdata  = had_prod[W-1:0];
                step_ovf = |had_prod[2*W-1:W];
            end
            OP_MUL: begin
                c_wdata   = acc_nxt[W-1:0];
                step_ovf  = |acc_nxt[AW-1:W];
                comp_step = (kk == LAST);
            end
            default: begin
                c_wdata = mat_a[col][row];
            end
        endcase
        c_we = (state == S_COMPUTE) && comp_step;
    end

    // NOTE: every signal driven in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start && sel_legal) state_nxt = S_LOAD_A;
            S_LOAD_A:  if (take_in && last_pos)
                           state_nxt = (op == OP_TRN) ? S_COMPUTE : S_LOAD_B;
            S_LOAD_B:  if (take_in && last_pos) state_nxt = S_COMPUTE;
            S_COMPUTE: if (comp_step && last_pos) state_nxt = S_DRAIN;
            S_DRAIN:   if (take_out && last_pos) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: the matrix storage is deliberately not reset; its contents are
    // always written before being read within an operation.
    always_ff @(posedge clk) begin
        if ((state == S_LOAD_A) && take_in) mat_a[row][col] <= eleIn;
        if ((state == S_LOAD_B) && take_in) mat_b[row][col] <= eleIn;
        if (c_we)                           mat_c[row][col] <= c_wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op          <= OP_ADD;
            row         <= '0;
            col         <= '0;
            kk          <= '0;
            acc         <= '0;
            eleOutValid <= 1'b0;
            eleOut      <= '0;
            done        <= 1'b0;
            ovf         <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    row <= '0;
                    col <= '0;
                    kk  <= '0;
                    if (start) begin
                        if (sel_legal) begin
                            op  <= sel;
                            ovf <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_LOAD_A, S_LOAD_B: begin
                    if (take_in) begin
                        row <= row_inc;
                        col <= col_inc;
                    end
                end
                S_COMPUTE: begin
                    if (op == OP_MUL) begin
                        acc <= acc_nxt;
                        kk  <= (kk == LAST) ? '0 : kk + 1'b1;
                    end
                    if (comp_step) begin
                        row <= row_inc;
                        col <= col_inc;
                        if (step_ovf) ovf <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    // First drain cycle registers C[0][0]; afterwards the
                    // output only moves when the sink takes it.
                    if (!eleOutValid) begin
                        eleOutValid <= 1'b1;
                        eleOut      <= mat_c[row][col];
                    end else if (eleOutReady) begin
                        row <= row_inc;
                        col <= col_inc;
                        if (last_pos) begin
                            eleOutValid <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            eleOut <= mat_c[row_inc][col_inc];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_matrix_stream.sv
// -----------------------------------------------------------------------------
// tb_alu_matrix_stream
//   Directed bench for alu_matrix_stream at W=8, N=2. A table of op vectors
//   (operands, expected result, expected ovf, output-stall pattern, input
//   gap) is run in a loop; reset, illegal-op and mid-load reset sequences
//   are written out by hand.
// -----------------------------------------------------------------------------
module tb_alu_matrix_stream;

    localparam int W    = 8;
    localparam int N    = 2;
    localparam int SELW = 3;

    logic            clk;
    logic            reset;
    logic            start;
    logic [SELW-1:0] sel;
    logic            eleInValid;
    logic [W-1:0]    eleIn;
    logic            eleInReady;
    logic            eleOutValid;
    logic [W-1:0]    eleOut;
    logic            eleOutReady;
    logic            busy;
    logic            done;
    logic            ovf;
    logic            err;

    int total = 0;
    int bad   = 0;

    alu_matrix_stream #(.W(W), .N(N), .SELW(SELW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .sel         (sel),
        .eleInValid  (eleInValid),
        .eleIn       (eleIn),
        .eleInReady  (eleInReady),
        .eleOutValid (eleOutValid),
        .eleOut      (eleOut),
        .eleOutReady (eleOutReady),
        .busy        (busy),
        .done        (done),
        .ovf         (ovf),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string            name;
        logic [2:0]       op;
        logic [3:0][7:0]  a;
        logic [3:0][7:0]  b;
        logic [3:0][7:0]  c;
        logic             ovf;
        logic             toggle;
        int               gap;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [3:0][7:0] m4(input int e0, input int e1, input int e2, input int e3);
        logic [3:0][7:0] r;
        r[0] = e0[7:0];
        r[1] = e1[7:0];
        r[2] = e2[7:0];
        r[3] = e3[7:0];
        return r;
    endfunction

    // Called just after a negedge; returns at the negedge after acceptance.
    task automatic send_elem(input logic [7:0] v);
        int t;
        eleInValid = 1'b1;
        eleIn      = v;
        t = 0;
        while (!eleInReady && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_wait", {31'd0, eleInReady}, 1);
        @(negedge clk);
        eleInValid = 1'b0;
        eleIn      = 8'hEE;
    endtask

    task automatic run_op(input vec_t v);
        logic [7:0] got [4];
        int         n, lat, k;
        logic       held, rdy;
        logic [7:0] held_val;

        @(negedge clk);
        start = 1'b1;
        sel   = v.op;
        @(negedge clk);
        start = 1'b0;
        check({v.name, "_busy"}, {31'd0, busy}, 1);
        check({v.name, "_ovf_clear"}, {31'd0, ovf}, 0);

        for (int i = 0; i < 4; i++) begin
            send_elem(v.a[i]);
            if (i < 3) repeat (v.gap) @(negedge clk);
        end
        check({v.name, "_ready_after_a"}, {31'd0, eleInReady}, (v.op == 3'd4) ? 0 : 1);
        if (v.op != 3'd4) begin
            for (int i = 0; i < 4; i++) begin
                send_elem(v.b[i]);
                if (i < 3) repeat (v.gap) @(negedge clk);
            end
        end

        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!eleOutValid && lat < 40);
        check({v.name, "_latency"}, lat, (v.op == 3'd3) ? 9 : 5);

        n    = 0;
        k    = 0;
        held = 1'b0;
        held_val = 8'd0;
        for (int t = 0; t < 60 && n < 4; t++) begin
            @(negedge clk);
            if (held) begin
                check({v.name, "_hold_valid"}, {31'd0, eleOutValid}, 1);
                check({v.name, "_hold_data"}, {24'd0, eleOut}, {24'd0, held_val});
                held = 1'b0;
            end
            if (eleOutValid) begin
                rdy = v.toggle ? (k % 2 == 0) : 1'b1;
                k++;
                eleOutReady = rdy;
                if (rdy) begin
                    got[n] = eleOut;
                    n++;
                end else begin
                    held     = 1'b1;
                    held_val = eleOut;
                end
            end else begin
                eleOutReady = 1'b0;
            end
        end
        check({v.name, "_drain_count"}, n, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < n) check($sformatf("%s_elem%0d", v.name, i), {24'd0, got[i]}, {24'd0, v.c[i]});
        end

        @(negedge clk);
        eleOutReady = 1'b0;
        check({v.name, "_done"}, {31'd0, done}, 1);
        check({v.name, "_valid_low"}, {31'd0, eleOutValid}, 0);
        check({v.name, "_idle"}, {31'd0, busy}, 0);
        @(negedge clk);
        check({v.name, "_done_clear"}, {31'd0, done}, 0);
        check({v.name, "_ovf"}, {31'd0, ovf}, {31'd0, v.ovf});
    endtask

    initial begin
        int done_cnt;

        vecs[0] = '{"add",     3'd0, m4(1, 2, 3, 4),      m4(10, 20, 30, 40), m4(11, 22, 33, 44),  1'b0, 1'b0, 0};
        vecs[1] = '{"add_ovf", 3'd0, m4(200, 200, 200, 200), m4(100, 100, 100, 100), m4(44, 44, 44, 44), 1'b1, 1'b0, 0};
        vecs[2] = '{"mul",     3'd3, m4(1, 2, 3, 4),      m4(5, 6, 7, 8),     m4(19, 22, 43, 50),  1'b0, 1'b0, 0};
        vecs[3] = '{"trn",     3'd4, m4(1, 2, 3, 4),      m4(0, 0, 0, 0),     m4(1, 3, 2, 4),      1'b0, 1'b1, 0};
        vecs[4] = '{"sub_gap", 3'd1, m4(9, 9, 9, 9),      m4(1, 2, 3, 10),    m4(8, 7, 6, 255),    1'b1, 1'b0, 2};
        vecs[5] = '{"had",     3'd2, m4(16, 3, 255, 2),   m4(16, 5, 2, 7),    m4(0, 15, 254, 14),  1'b1, 1'b0, 0};

        reset       = 1'b0;
        start       = 1'b0;
        sel         = '0;
        eleInValid  = 1'b0;
        eleIn       = '0;
        eleOutReady = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_flags", {26'd0, busy, done, ovf, err, eleOutValid, eleInReady}, 0);
        check("reset_eleout", {24'd0, eleOut}, 0);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i]);
            if (i == 1) begin
                repeat (3) @(negedge clk);
                check("ovf_sticky", {31'd0, ovf}, 1);
            end
        end

        // Illegal op code: err pulse, no state change.
        @(negedge clk);
        start = 1'b1;
        sel   = 3'd6;
        @(negedge clk);
        start = 1'b0;
        check("illegal_err", {31'd0, err}, 1);
        check("illegal_busy", {31'd0, busy}, 0);
        @(negedge clk);
        check("illegal_err_clear", {31'd0, err}, 0);
        check("illegal_busy_later", {31'd0, busy}, 0);

        // Reset in the middle of LOAD_B aborts without a done pulse.
        @(negedge clk);
        start = 1'b1;
        sel   = 3'd0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) send_elem(8'd99);
        send_elem(8'd77);
        check("midload_ready", {31'd0, eleInReady}, 1);
        check("midload_busy", {31'd0, busy}, 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midreset_flags", {26'd0, busy, done, ovf, err, eleOutValid, eleInReady}, 0);
        done_cnt = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("midreset_no_done", done_cnt, 0);
        check("midreset_idle", {31'd0, busy}, 0);

        vecs[0].name = "add_after_reset";
        run_op(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
